pulse_train_tx: RTL and testbench
=================================

Name: pulse_train_tx

Overview:
Moore-style transmitter that generates the serial input stream consumed by the team's pulse-counting Moore detectors. On a start handshake it emits a programmable number of high cycles on x_out. The high cycles are separated by a programmable number of low gap cycles. It then signals completion for one cycle. It sits upstream of a counter/detector FSM and drives that block's x_in directly.

Parameters:
CNT_W, 4, width of the pulse-count request (max CNT_W'1s pulses)
GAP_W, 4, width of the inter-pulse gap length in cycles

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request to transmit; accepted only when ready=1
count  input  CNT_W  number of pulses to emit, sampled on accept
gap  input  GAP_W  low cycles between consecutive pulses, sampled on accept
ready  output  1  high in IDLE only; start accepted when start&ready at clk edge
x_out  output  1  serial pulse stream to the downstream detector's x_in
busy  output  1  high while in PULSE or GAP
done  output  1  single-cycle completion strobe

Behaviour:
- Clock and reset: reset rst, asynchronous, active-low; clock clk.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - remaining, gap_reg and gap_cnt cleared.
  - x_out=0, busy=0, done=0, ready=1.
  - Reset mid-transmission aborts immediately: x_out drops with rst, no done strobe is issued, and the block is ready on the first edge after release.
- Moore outputs, decoded from state only (no combinational path from start, count or gap):
  - ready = (state==IDLE)
  - x_out = (state==PULSE)
  - busy = (state==PULSE or GAP)
  - done = (state==DONE)
- States: IDLE, PULSE, GAP, DONE (2-bit encoding).
- IDLE:
  - start=1, count!=0: latch remaining<=count and gap_reg<=gap; next PULSE.
  - start=1, count==0: next DONE (no pulses, done still strobes).
  - start=0: stay.
- PULSE (one cycle per pulse), remaining<=remaining-1:
  - remaining==1: next DONE.
  - Else gap_reg==0: next PULSE; x_out stays high for back-to-back cycles.
  - Else: gap_cnt<=gap_reg; next GAP.
- GAP:
  - gap_cnt<=gap_cnt-1 each cycle.
  - gap_cnt==1: next PULSE.
  - Net effect: exactly gap_reg low cycles between pulses.
- DONE: one cycle; next IDLE unconditionally. start during DONE is ignored, because ready=0.
- start while not in IDLE is ignored. Changes to count or gap after accept have no effect.
- Timing:
  - Accept at edge k: first x_out high cycle is k+1.
  - Total busy cycles = count + (count-1)*gap.
  - done is high in the cycle after the last pulse.
  - ready returns one cycle after done.
- Arithmetic: unsigned.
  - remaining and gap_cnt never underflow, because transitions occur at value 1.
  - Maximum count = 2^CNT_W-1.
  - Maximum gap = 2^GAP_W-1.

Test Plan:
1. rst pulsed low mid-simulation with start=1 -> ready=1, x_out=0, busy=0, done=0 while rst=0; nothing starts until rst=1 and next edge.
2. count=3, gap=2, start for one cycle -> x_out pattern 1,0,0,1,0,0,1 starting the cycle after accept; busy high 7 cycles; done high cycle 8; ready high cycle 9.
3. count=4, gap=0 driving a mod-4 Moore pulse detector from reset -> x_out high 4 consecutive cycles; detector output high after the 3rd high cycle and back to S0 after the 4th.
4. count=0, start=1 -> x_out never high, busy never high, done high exactly one cycle after accept.
5. Second start asserted during PULSE/GAP/DONE with different count/gap -> ignored; original pulse train unchanged; new request accepted only once ready=1.
6. count=15, gap=15 (max) -> 15 pulses, 14 gaps of 15 cycles, busy=225 cycles, no wrap; rst asserted low at pulse 7 -> x_out low immediately, no done.

Source files
------------

// File: rtl/pulse_train_tx.sv
// Pulse-train source for the pulse-counting detectors: emits `count` one-cycle highs separated by `gap` lows.
// First pulse one cycle after start&ready; start is refused (ready=0) from accept until one cycle after done.
module pulse_train_tx #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             ready,
  output logic             x_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        if (remaining == CNT_W'(1)) begin
          state_nxt = DONE;
        end else if (gap_reg == '0) begin
          state_nxt = PULSE;
        end else begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_nxt = PULSE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    x_out = (state == PULSE);
    busy  = (state == PULSE) || (state == GAP);
    done  = (state == DONE);
  end

  // Counters only ever step down from values >= 1, so they cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      gap_reg   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (count != '0)) begin
            remaining <= count;
            gap_reg   <= gap;
          end
        end
        PULSE: begin
          remaining <= remaining - 1'b1;
          if ((remaining != CNT_W'(1)) && (gap_reg != '0)) begin
            gap_cnt <= gap_reg;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx, with a mod-4 pulse-counting detector hung on x_out.
module tb_pulse_train_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic [3:0] gap;
  logic       ready;
  logic       x_out;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  // Downstream mod-4 Moore detector: output high once three highs have been counted.
  logic [1:0] det_cnt;
  logic       det_out;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det_cnt <= 2'd0;
    else if (x_out) det_cnt <= det_cnt + 2'd1;
  end
  assign det_out = (det_cnt == 2'd3);

  pulse_train_tx #(.CNT_W(4), .GAP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .gap   (gap),
    .ready (ready),
    .x_out (x_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, ready, 1);
    check({tag, " x_out"}, x_out, 0);
    check({tag, " busy"},  busy,  0);
    check({tag, " done"},  done,  0);
  endtask

  // Sends one request and checks every cycle up to the return of ready.
  // noise: keep offering a different request while the train runs.
  // abort_i: pull rst low in that cycle and stop (0 = never).
  task automatic run_train(input string name, input int cnt, input int gp,
                           input bit noise, input bit chk_det, input int abort_i);
    int busy_len;
    bit exp_x;
    busy_len = (cnt == 0) ? 0 : cnt + (cnt - 1) * gp;
    start = 1'b1;
    count = 4'(cnt);
    gap   = 4'(gp);
    @(posedge clk); #1;
    for (int i = 1; i <= busy_len + 2; i++) begin
      exp_x = (i <= busy_len) && (((i - 1) % (gp + 1)) == 0);
      check($sformatf("%s c%0d x_out", name, i), x_out, int'(exp_x));
      check($sformatf("%s c%0d busy",  name, i), busy,  int'(i <= busy_len));
      check($sformatf("%s c%0d done",  name, i), done,  int'(i == busy_len + 1));
      check($sformatf("%s c%0d ready", name, i), ready, int'(i == busy_len + 2));
      if (chk_det) check($sformatf("%s c%0d det_out", name, i), det_out, int'(i == 4));
      if (i == abort_i) begin
        rst = 1'b0;
        #1;
        check_idle($sformatf("%s abort", name));
        return;
      end
      if (noise && (i <= busy_len + 1)) begin
        start = 1'b1;
        count = 4'd7;
        gap   = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    count = 4'd0;
    gap   = 4'd0;
    #1;
    check_idle("reset");
    #11;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");

    run_train("c3g2", 3, 2, 1'b0, 1'b0, 0);
    run_train("c0", 0, 5, 1'b0, 1'b0, 0);
    run_train("c2g3_noise", 2, 3, 1'b1, 1'b0, 0);
    run_train("c1g0", 1, 0, 1'b0, 1'b0, 0);

    // Mid-simulation reset with a pending start request.
    start = 1'b1;
    count = 4'd4;
    gap   = 4'd0;
    rst   = 1'b0;
    #1;
    check_idle("rst_low");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_idle($sformatf("rst_hold%0d", k));
    end
    rst = 1'b1;
    #1;
    check_idle("rst_release");
    run_train("c4g0_det", 4, 0, 1'b0, 1'b1, 0);

    run_train("c15g15", 15, 15, 1'b0, 1'b0, 0);
    run_train("c15g15_abort", 15, 15, 1'b0, 1'b0, 6 * 16 + 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_idle($sformatf("abort_hold%0d", k));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("abort_release");
    run_train("c2g1_after", 2, 1, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
